// File: rtl/hazard_fwd_unit.sv
// hazard_fwd_unit: load-use/redirect hazard control and operand forwarding for the in-order pipe.
// Define HAZ_PERF_CNT_EN to add the stall/flush/forward event counters.
module hazard_fwd_unit #(
  parameter int DATA_W     = 32,
  parameter int RA_W       = 5,
  parameter int FWD_STAGES = 2,
  parameter int LOAD_LAT   = 0
) (
  input  logic                         clock,
  input  logic                         reset_n,
  input  logic [RA_W-1:0]              fd_rs,
  input  logic [RA_W-1:0]              fd_rt,
  input  logic                         fd_src1,
  input  logic                         fd_src2,
  input  logic                         fd_store,
  input  logic [RA_W-1:0]              dx_rs,
  input  logic [RA_W-1:0]              dx_rt,
  input  logic [RA_W-1:0]              dx_rd,
  input  logic                         dx_src1,
  input  logic                         dx_src2,
  input  logic                         dx_dest,
  input  logic                         dx_load,
  input  logic [DATA_W-1:0]            rs_reg,
  input  logic [DATA_W-1:0]            rt_reg,
  input  logic [FWD_STAGES*DATA_W-1:0] fwd_data,
  input  logic                         redirect,
  input  logic                         dmem_busy,
  output logic [DATA_W-1:0]            a_out,
  output logic [DATA_W-1:0]            b_out,
  output logic                         stall_fd,
  output logic                         bubble_dx,
  output logic                         flush_fd,
  output logic                         flush_dx,
`ifdef HAZ_PERF_CNT_EN
  output logic [31:0]                  stall_cnt,
  output logic [31:0]                  flush_cnt,
  output logic [31:0]                  fwd_cnt,
`endif
  output logic                         freeze
);
  localparam int CW = $clog2(LOAD_LAT + 2);
  logic [CW-1:0] cnt;
  logic [FWD_STAGES-1:0] tag_v, tag_ld;
  logic [FWD_STAGES-1:0][RA_W-1:0] tag_rd;
  logic use_hit, trigger;
  assign freeze = dmem_busy;
  assign flush_fd = redirect;
  assign flush_dx = redirect;
  // with no extra load latency a store's data operand can still be forwarded in time
  assign use_hit = (fd_src1 && fd_rs == dx_rd) ||
                   (fd_src2 && fd_rt == dx_rd && !(fd_store && LOAD_LAT == 0));
  assign trigger = cnt == '0 && dx_load && dx_dest && dx_rd != '0 && use_hit;
  assign stall_fd = !redirect && (trigger || cnt != '0);
  assign bubble_dx = stall_fd;
  // oldest stage first so the youngest matching stage is the last writer
  always_comb begin
    a_out = rs_reg;
    b_out = rt_reg;
    for (int k = FWD_STAGES - 1; k >= 0; k--) begin
      if (dx_src1 && dx_rs != '0 && tag_v[k] && tag_rd[k] == dx_rs) a_out = fwd_data[k*DATA_W +: DATA_W];
      if (dx_src2 && dx_rt != '0 && tag_v[k] && tag_rd[k] == dx_rt) b_out = fwd_data[k*DATA_W +: DATA_W];
    end
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      cnt <= '0;
      tag_v <= '0;
      tag_ld <= '0;
      tag_rd <= '0;
    end else if (!freeze) begin
      cnt <= redirect ? '0 : trigger ? CW'(LOAD_LAT) : cnt - CW'(cnt != '0);
      tag_v <= {tag_v[FWD_STAGES-2:0], dx_dest && dx_rd != '0};
      tag_ld <= {tag_ld[FWD_STAGES-2:0], dx_load};
      tag_rd <= {tag_rd[FWD_STAGES-2:0], dx_rd};
    end
  end
  // a consumer must never reach a load tag before its data is usable
  always_ff @(posedge clock)
    if (reset_n)
      for (int k = 0; k < FWD_STAGES; k++)
        assert (!(tag_v[k] && tag_ld[k] && k < LOAD_LAT + 1 &&
                  ((dx_src1 && tag_rd[k] == dx_rs) || (dx_src2 && tag_rd[k] == dx_rt))));
`ifdef HAZ_PERF_CNT_EN
  logic fwd_hit;
  always_comb begin
    fwd_hit = 1'b0;
    for (int k = 0; k < FWD_STAGES; k++)
      fwd_hit = fwd_hit | (tag_v[k] && ((dx_src1 && dx_rs != '0 && tag_rd[k] == dx_rs) ||
                                        (dx_src2 && dx_rt != '0 && tag_rd[k] == dx_rt)));
  end
  always_ff @(posedge clock) begin
    if (!reset_n) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
      fwd_cnt <= '0;
    end else begin
      stall_cnt <= stall_cnt + 32'(stall_fd && !freeze);
      flush_cnt <= flush_cnt + 32'(redirect);
      fwd_cnt <= fwd_cnt + 32'(fwd_hit);
    end
  end
`endif
endmodule

// File: tb/tb_hazard_fwd_unit.sv
// tb_hazard_fwd_unit: vector table, multi-cycle sequences and a random reference-model run
// against a LOAD_LAT=0/FWD_STAGES=2 instance and a LOAD_LAT=2/FWD_STAGES=4 instance.
module tb_hazard_fwd_unit;
  logic clock = 1'b0;
  always #5 clock = ~clock;
  logic rn0 = 1'b0, rn2 = 1'b0;
  logic [4:0] fd_rs, fd_rt, dx_rs, dx_rt, dx_rd;
  logic fd_src1, fd_src2, fd_store, dx_src1, dx_src2, dx_dest, dx_load, redirect, dmem_busy;
  logic [31:0] rs_reg, rt_reg;
  logic [31:0] fw[2][4];
  logic [63:0] fd0;
  logic [127:0] fd2;
  assign fd0 = {fw[0][1], fw[0][0]};
  assign fd2 = {fw[1][3], fw[1][2], fw[1][1], fw[1][0]};
  logic [31:0] a0, b0, a2, b2;
  logic st0, bu0, ff0, fx0, fz0, st2, bu2, ff2, fx2, fz2;
`ifdef HAZ_PERF_CNT_EN
  logic [31:0] sc0, fc0, wc0, sc2, fc2, wc2;
`endif
  hazard_fwd_unit #(.DATA_W(32), .RA_W(5), .FWD_STAGES(2), .LOAD_LAT(0)) u0 (
    .clock(clock), .reset_n(rn0), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_src1(fd_src1),
    .fd_src2(fd_src2), .fd_store(fd_store), .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd),
    .dx_src1(dx_src1), .dx_src2(dx_src2), .dx_dest(dx_dest), .dx_load(dx_load),
    .rs_reg(rs_reg), .rt_reg(rt_reg), .fwd_data(fd0), .redirect(redirect), .dmem_busy(dmem_busy),
    .a_out(a0), .b_out(b0), .stall_fd(st0), .bubble_dx(bu0), .flush_fd(ff0), .flush_dx(fx0),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(sc0), .flush_cnt(fc0), .fwd_cnt(wc0),
`endif
    .freeze(fz0));
  hazard_fwd_unit #(.DATA_W(32), .RA_W(5), .FWD_STAGES(4), .LOAD_LAT(2)) u2 (
    .clock(clock), .reset_n(rn2), .fd_rs(fd_rs), .fd_rt(fd_rt), .fd_src1(fd_src1),
    .fd_src2(fd_src2), .fd_store(fd_store), .dx_rs(dx_rs), .dx_rt(dx_rt), .dx_rd(dx_rd),
    .dx_src1(dx_src1), .dx_src2(dx_src2), .dx_dest(dx_dest), .dx_load(dx_load),
    .rs_reg(rs_reg), .rt_reg(rt_reg), .fwd_data(fd2), .redirect(redirect), .dmem_busy(dmem_busy),
    .a_out(a2), .b_out(b2), .stall_fd(st2), .bubble_dx(bu2), .flush_fd(ff2), .flush_dx(fx2),
`ifdef HAZ_PERF_CNT_EN
    .stall_cnt(sc2), .flush_cnt(fc2), .fwd_cnt(wc2),
`endif
    .freeze(fz2));

  int n_chk = 0, n_fail = 0;
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic set_fd(input logic [4:0] rs, input logic [4:0] rt, input logic s1, input logic s2, input logic st);
    fd_rs = rs; fd_rt = rt; fd_src1 = s1; fd_src2 = s2; fd_store = st;
  endtask
  task automatic set_dx(input logic [4:0] rs, input logic [4:0] rt, input logic [4:0] rd,
                        input logic s1, input logic s2, input logic de, input logic ld);
    dx_rs = rs; dx_rt = rt; dx_rd = rd; dx_src1 = s1; dx_src2 = s2; dx_dest = de; dx_load = ld;
  endtask
  task automatic idle();
    set_fd(0, 0, 0, 0, 0);
    set_dx(0, 0, 0, 0, 0, 0, 0);
    redirect = 1'b0;
    dmem_busy = 1'b0;
  endtask
  task automatic reset_dut(input logic e0, input logic e2);
    @(negedge clock);
    idle();
    rn0 = 1'b0; rn2 = 1'b0;
    @(negedge clock);
    rn0 = e0; rn2 = e2;
  endtask

  localparam logic [31:0] R = 32'h1111_1111, T = 32'h2222_2222, D = 32'hDEAD_BEEF;
  typedef struct {
    logic [4:0] f_rs, f_rt; logic f_s1, f_s2, f_st;
    logic [4:0] d_rs, d_rt, d_rd; logic d_s1, d_s2, d_de, d_ld;
    logic rdr, busy;
    logic [31:0] e_a, e_b; logic e_st, e_fl;
  } vec_t;
  vec_t tbl[16];

  typedef struct packed { logic v; logic [4:0] rd; logic ld; } tag_t;
  tag_t mt[2][4];
  int rem[2];

  function automatic logic [31:0] m_op(int i, logic src, logic [4:0] r, logic [31:0] rv);
    for (int k = 0; k < (i != 0 ? 4 : 2); k++)
      if (src && r != 0 && mt[i][k].v && mt[i][k].rd == r) return fw[i][k];
    return rv;
  endfunction
  function automatic logic m_trig(int i);
    int ll = i != 0 ? 2 : 0;
    return rem[i] == 0 && dx_load && dx_dest && dx_rd != 0 &&
           ((fd_src1 && fd_rs == dx_rd) || (fd_src2 && fd_rt == dx_rd && !(fd_store && ll == 0)));
  endfunction

  initial begin
    fw[0][0] = 32'h0000_0005; fw[0][1] = D;
    for (int k = 0; k < 4; k++) fw[1][k] = 32'hA000_0000 + k;
    fw[0][2] = '0; fw[0][3] = '0;
    rs_reg = R; rt_reg = T;
    idle();
    tbl[0]  = '{3,1,1,1,0, 1,2,3,1,1,1,0, 0,0, R,T,0,0};
    tbl[1]  = '{1,0,1,0,0, 3,1,6,1,1,1,0, 0,0, 32'h5,T,0,0};
    tbl[2]  = '{4,1,1,1,0, 1,0,4,1,0,1,1, 0,0, R,T,1,0};
    tbl[3]  = '{4,1,1,1,0, 0,0,0,0,0,0,0, 0,0, R,T,0,0};
    tbl[4]  = '{0,0,0,0,0, 4,1,5,1,1,1,0, 0,0, D,T,0,0};
    tbl[5]  = '{2,4,1,1,1, 1,0,4,1,0,1,1, 0,0, R,T,0,0};
    tbl[6]  = '{0,0,0,0,0, 0,0,7,0,0,1,0, 0,0, R,T,0,0};
    tbl[7]  = '{0,0,0,0,0, 0,0,7,0,0,1,0, 0,0, R,T,0,0};
    tbl[8]  = '{0,0,0,0,0, 7,0,0,1,1,1,0, 0,0, 32'h5,T,0,0};
    tbl[9]  = '{0,0,0,0,0, 0,7,0,1,1,0,0, 0,0, R,D,0,0};
    tbl[10] = '{4,0,1,0,0, 1,0,4,0,0,1,1, 1,0, R,T,0,1};
    tbl[11] = '{4,0,1,0,0, 0,0,0,0,0,0,0, 0,0, R,T,0,0};
    tbl[12] = '{0,0,1,0,0, 0,0,0,0,0,1,1, 0,0, R,T,0,0};
    tbl[13] = '{0,9,0,1,0, 0,0,9,0,0,1,1, 0,0, R,T,1,0};
    tbl[14] = '{0,9,0,1,0, 0,0,9,0,0,1,1, 0,1, R,T,1,0};
    tbl[15] = '{0,9,0,1,1, 0,0,9,0,0,1,1, 0,0, R,T,0,0};

    // LOAD_LAT=0 instance: reset state, then the vector table
    reset_dut(1'b1, 1'b0);
    #1;
    chk("rst_stall", st0, 0); chk("rst_bubble", bu0, 0); chk("rst_flush", ff0, 0);
    chk("rst_a", a0, R); chk("rst_b", b0, T);
    for (int i = 0; i < 16; i++) begin
      @(negedge clock);
      set_fd(tbl[i].f_rs, tbl[i].f_rt, tbl[i].f_s1, tbl[i].f_s2, tbl[i].f_st);
      set_dx(tbl[i].d_rs, tbl[i].d_rt, tbl[i].d_rd, tbl[i].d_s1, tbl[i].d_s2, tbl[i].d_de, tbl[i].d_ld);
      redirect = tbl[i].rdr; dmem_busy = tbl[i].busy;
      #1;
      chk($sformatf("v%0d_a", i), a0, tbl[i].e_a);
      chk($sformatf("v%0d_b", i), b0, tbl[i].e_b);
      chk($sformatf("v%0d_stall", i), st0, 32'(tbl[i].e_st));
      chk($sformatf("v%0d_bubble", i), bu0, 32'(tbl[i].e_st));
      chk($sformatf("v%0d_flush_fd", i), ff0, 32'(tbl[i].e_fl));
      chk($sformatf("v%0d_flush_dx", i), fx0, 32'(tbl[i].e_fl));
      chk($sformatf("v%0d_freeze", i), fz0, 32'(tbl[i].busy));
    end

    // LOAD_LAT=2: load-use on rs, then store data on rt -> 3 stall cycles, then forward from stage 4
    for (int t = 0; t < 2; t++) begin
      reset_dut(1'b0, 1'b1);
      for (int c = 0; c < 5; c++) begin
        @(negedge clock);
        idle();
        if (t == 0) set_fd(4, 1, 1, 1, 0); else set_fd(2, 4, 1, 1, 1);
        if (c == 0) set_dx(1, 0, 4, 1, 0, 1, 1);
        if (c == 4) begin set_fd(0, 0, 0, 0, 0); set_dx(4, 4, 5, t == 0, t == 1, 1, 0); end
        #1;
        if (c < 4) chk($sformatf("lat2_stall_t%0d_c%0d", t, c), st2, 32'(c < 3));
        else if (t == 0) chk("lat2_fwd_a", a2, 32'hA000_0003);
        else chk("lat2_fwd_b", b2, 32'hA000_0003);
      end
    end

    // LOAD_LAT=2: redirect during countdown clears it
    reset_dut(1'b0, 1'b1);
    @(negedge clock); set_fd(4, 0, 1, 0, 0); set_dx(1, 0, 4, 0, 0, 1, 1);
    #1 chk("rdc_trig", st2, 1);
    @(negedge clock); idle(); redirect = 1'b1;
    #1 chk("rdc_flush_fd", ff2, 1); chk("rdc_flush_dx", fx2, 1);
    @(negedge clock); idle(); set_fd(4, 0, 1, 0, 0);
    #1 chk("rdc_after_stall", st2, 0); chk("rdc_after_flush", ff2, 0);

    // LOAD_LAT=2: redirect in same cycle as trigger wins
    reset_dut(1'b0, 1'b1);
    @(negedge clock); set_fd(4, 0, 1, 0, 0); set_dx(1, 0, 4, 0, 0, 1, 1); redirect = 1'b1;
    #1 chk("rdt_stall", st2, 0); chk("rdt_flush", fx2, 1);
    @(negedge clock); idle(); set_fd(7, 0, 1, 0, 0);
    #1 chk("rdt_no_count", st2, 0);

    // LOAD_LAT=2: freeze for 3 cycles mid-countdown holds counter and tags
    reset_dut(1'b0, 1'b1);
    for (int c = 0; c < 8; c++) begin
      @(negedge clock);
      idle();
      set_fd(4, 0, 1, 0, 0);
      if (c == 0) set_dx(1, 0, 4, 0, 0, 1, 1);
      dmem_busy = c >= 1 && c <= 3;
      if (c == 7) begin set_fd(0, 0, 0, 0, 0); set_dx(4, 0, 6, 1, 0, 1, 0); end
      #1;
      chk($sformatf("frz_freeze_c%0d", c), fz2, 32'(c >= 1 && c <= 3));
      if (c < 7) chk($sformatf("frz_stall_c%0d", c), st2, 32'(c <= 5));
      else chk("frz_fwd_a", a2, 32'hA000_0003);
    end

    // LOAD_LAT=2: reset mid-stall
    reset_dut(1'b0, 1'b1);
    @(negedge clock); set_fd(4, 0, 1, 0, 0); set_dx(1, 0, 4, 0, 0, 1, 1);
    #1 chk("rms_trig", st2, 1);
    @(negedge clock); set_dx(0, 0, 0, 0, 0, 0, 0);
    #1 chk("rms_count", st2, 1);
    rn2 = 1'b0;
    @(negedge clock); rn2 = 1'b1; set_dx(4, 0, 0, 1, 0, 0, 0);
    #1 chk("rms_stall", st2, 0); chk("rms_bubble", bu2, 0); chk("rms_a", a2, R); chk("rms_flush", fx2, 0);

    // random run on both instances against the reference model
    reset_dut(1'b1, 1'b1);
    for (int i = 0; i < 2; i++) begin
      rem[i] = 0;
      for (int k = 0; k < 4; k++) mt[i][k] = '0;
    end
    for (int n = 0; n < 2000; n++) begin
      @(negedge clock);
      set_fd(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 1'($urandom), 1'($urandom), 1'($urandom));
      set_dx(5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
             1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) != 0), $urandom_range(0, 2) == 0);
      redirect = $urandom_range(0, 7) == 0;
      dmem_busy = $urandom_range(0, 5) == 0;
      rs_reg = $urandom; rt_reg = $urandom;
      for (int i = 0; i < 2; i++) for (int k = 0; k < 4; k++) fw[i][k] = $urandom;
      for (int i = 0; i < 2; i++)
        for (int k = 0; k <= (i != 0 ? 2 : 0); k++)
          if (mt[i][k].v && mt[i][k].ld) begin
            if (mt[i][k].rd == dx_rs) dx_src1 = 1'b0;
            if (mt[i][k].rd == dx_rt) dx_src2 = 1'b0;
          end
      #1;
      for (int i = 0; i < 2; i++) begin
        logic tr, es;
        tr = m_trig(i);
        es = !redirect && (rem[i] > 0 || tr);
        chk($sformatf("rnd%0d_a_%0d", i, n), i != 0 ? a2 : a0, m_op(i, dx_src1, dx_rs, rs_reg));
        chk($sformatf("rnd%0d_b_%0d", i, n), i != 0 ? b2 : b0, m_op(i, dx_src2, dx_rt, rt_reg));
        chk($sformatf("rnd%0d_stall_%0d", i, n), i != 0 ? st2 : st0, 32'(es));
        chk($sformatf("rnd%0d_bubble_%0d", i, n), i != 0 ? bu2 : bu0, 32'(es));
        chk($sformatf("rnd%0d_ffd_%0d", i, n), i != 0 ? ff2 : ff0, 32'(redirect));
        chk($sformatf("rnd%0d_fdx_%0d", i, n), i != 0 ? fx2 : fx0, 32'(redirect));
        chk($sformatf("rnd%0d_frz_%0d", i, n), i != 0 ? fz2 : fz0, 32'(dmem_busy));
        if (!dmem_busy) begin
          for (int k = 3; k > 0; k--) mt[i][k] = mt[i][k-1];
          mt[i][0] = '{dx_dest && dx_rd != 0, dx_rd, dx_load};
          rem[i] = redirect ? 0 : tr ? (i != 0 ? 2 : 0) : (rem[i] > 0 ? rem[i] - 1 : 0);
        end
      end
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/hazard_fwd_unit.md
Name: hazard_fwd_unit

Overview:
- Parametrised hazard-detection and forwarding controller for the in-order MIPS pipeline; sits beside decode/execute.
- Replaces the ad-hoc bypass muxes and load-use/branch-recovery logic with one block.
- Owns an internal destination-tag pipeline of FWD_STAGES entries (X/M, M/W, ...).
- Generalises the current logic to configurable load latency, forwarding depth and data-memory freeze.

Parameters:
DATA_W, 32, datapath width
RA_W, 5, register address width
FWD_STAGES, 2, tag stages after execute that can forward (must be >= 2+LOAD_LAT)
LOAD_LAT, 0, extra cycles after M/W-equivalent before load data is usable

Ports:
clock  in  1  pipeline clock
reset_n  in  1  synchronous active-low reset
fd_rs, fd_rt  in  RA_W  decode-stage source regs
fd_src1, fd_src2, fd_store  in  1  decode uses rs / uses rt / is store
dx_rs, dx_rt, dx_rd  in  RA_W  execute-stage sources and resolved destination
dx_src1, dx_src2, dx_dest, dx_load  in  1  execute-stage control bits
rs_reg, rt_reg  in  DATA_W  registered regfile values for the DX instruction
fwd_data  in  FWD_STAGES*DATA_W  result of stage k in slice k-1; stage 1 is X/M
redirect  in  1  execute resolved branch/jump with target != fetch PC
dmem_busy  in  1  data memory not ready; freeze whole pipe
a_out, b_out  out  DATA_W  forwarded ALU operands
stall_fd  out  1  hold PC and F/D register
bubble_dx  out  1  load NOP/zero control into D/X
flush_fd, flush_dx  out  1  squash wrong-path instructions
freeze  out  1  hold every pipeline register (= dmem_busy)

Behaviour:
- Reset (reset_n=0 at posedge):
  - all tag stages invalid; stall counter = 0.
  - Outputs are combinational from this state: stall_fd=0, bubble_dx=0, flush_*=0 absent redirect.
- Tag pipeline:
  - Each tag is {valid, rd, is_load}.
  - On a posedge with freeze=0: stage1 <= {dx_dest && dx_rd!=0, dx_rd, dx_load}, and stage k <= stage k-1.
  - freeze=1 holds all tags and the stall counter.
- Forwarding, A (B is identical using dx_rt/dx_src2/rt_reg):
  - Search stages 1..FWD_STAGES, youngest first.
  - The first valid tag with rd==dx_rs && dx_src1 supplies fwd_data slice.
  - Else a_out=rs_reg.
  - r0 is never forwarded; a_out=rs_reg when dx_rs==0.
  - A match on a load tag in stage k < 2+LOAD_LAT is unreachable by construction; if it occurs (assertion), use that stage anyway.
- Load-use stall:
  - Triggers when the counter is 0, dx_load && dx_dest, and either (fd_src1 && fd_rs==dx_rd) or (fd_src2 && fd_rt==dx_rd && !(fd_store && LOAD_LAT==0)).
  - Ignored when dx_rd==0.
  - On trigger: stall_fd=1 and bubble_dx=1 this cycle; counter loads LOAD_LAT.
  - While counter>0: stall_fd=1, bubble_dx=1, counter decrements per unfrozen cycle.
  - Total stall = 1+LOAD_LAT cycles.
- Redirect:
  - flush_fd=1 and flush_dx=1 for that cycle (the D/X input becomes a NOP).
  - redirect has priority over a load-use trigger in the same cycle: no stall, counter unchanged.
  - A redirect during an active countdown clears the counter to 0.
- Freeze:
  - freeze = dmem_busy, combinational.
  - stall/flush outputs remain asserted but take effect only when freeze drops.
- reset_n low mid-stall: counter and tags cleared at that edge.

Optional Feature:
HAZ_PERF_CNT_EN
- Defined:
  - adds outputs stall_cnt, flush_cnt, fwd_cnt (32 bits each, wrap at 2^32).
  - stall_cnt counts unfrozen cycles with stall_fd=1.
  - flush_cnt counts redirect cycles.
  - fwd_cnt counts cycles where A or B forwards.
  - All three clear on reset.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- ADD r3 in DX, then SUB using r3 as rs one cycle later -> a_out = fwd_data stage1 (0x0000_0005 driven), rs_reg ignored.
- LW r4 in DX, decode ADD r5,r4,r1, LOAD_LAT=0 -> exactly 1 cycle stall_fd=bubble_dx=1; next cycle a_out = stage2 data 0xDEAD_BEEF. With LOAD_LAT=2 -> 3 stall cycles.
- LW r4 followed by SW r4 (rt only, store), LOAD_LAT=0 -> no stall. Same with LOAD_LAT=1 -> 2-cycle stall.
- Both stage1 and stage2 valid with rd=r7, DX rs=r7 -> stage1 value wins; dx_rs=r0 with a stage rd=0 -> rs_reg used.
- redirect asserted in the same cycle as a load-use trigger -> flush_fd=flush_dx=1, stall_fd=0. Redirect during countdown (LOAD_LAT=2) -> counter cleared, stall_fd=0 next cycle.
- dmem_busy high 3 cycles during stall countdown -> tags/counter hold, freeze=1; countdown resumes after; reset_n low mid-stall -> all outputs idle next cycle.
